// File: rtl/mycpu_exe_stage_if.sv
// rtl/mycpu_exe_stage_if.sv - decode/exe/memory handshake bundle for mycpu_exe_stage
interface mycpu_exe_stage_if;
  logic        ds_valid;
  logic        es_allowin;
  logic [31:0] rs_cont;
  logic [31:0] rt_cont;
  logic [4:0]  rd;
  logic [4:0]  rt;
  logic [15:0] immediate;
  logic [3:0]  aluop;
  logic        use_imm;
  logic        imm_sext;
  logic        dst_rt;
  logic        reg_we;
  logic        mem_re;
  logic        mem_we;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [31:0] es_result;
  logic [31:0] es_store_data;
  logic [4:0]  es_dest;
  logic        es_reg_we;
  logic        es_mem_re;
  logic        es_mem_we;
  logic        es_busy;

  modport master (
    output ds_valid, rs_cont, rt_cont, rd, rt, immediate, aluop,
           use_imm, imm_sext, dst_rt, reg_we, mem_re, mem_we, ms_allowin,
    input  es_allowin, es_to_ms_valid, es_result, es_store_data, es_dest,
           es_reg_we, es_mem_re, es_mem_we, es_busy
  );

  modport slave (
    input  ds_valid, rs_cont, rt_cont, rd, rt, immediate, aluop,
           use_imm, imm_sext, dst_rt, reg_we, mem_re, mem_we, ms_allowin,
    output es_allowin, es_to_ms_valid, es_result, es_store_data, es_dest,
           es_reg_we, es_mem_re, es_mem_we, es_busy
  );
endinterface

// File: rtl/mycpu_exe_stage.sv
// rtl/mycpu_exe_stage.sv - execute stage: ALU plus optional 32-cycle restoring DIVU
// Define MYCPU_EXE_DIV_EN to build the divider; otherwise aluop 12/13 return 0.
module mycpu_exe_stage (
  input  logic              clk,
  input  logic              rst,
  mycpu_exe_stage_if.slave  io_es
);

  logic        r_es_valid;
  logic [31:0] r_rs;
  logic [31:0] r_rt_cont;
  logic [15:0] r_imm;
  logic [3:0]  r_aluop;
  logic        r_use_imm;
  logic        r_imm_sext;
  logic        r_reg_we;
  logic        r_mem_re;
  logic        r_mem_we;
  logic [4:0]  r_dest;

  logic        w_ready_go;
  logic        w_allowin;
  logic        w_to_ms_valid;
  logic        w_busy;
  logic [31:0] w_b;
  logic [31:0] w_alu;
  logic [4:0]  w_shamt;

  assign w_allowin     = !r_es_valid || (w_ready_go && io_es.ms_allowin);
  assign w_to_ms_valid = r_es_valid && w_ready_go;
  assign w_shamt       = r_imm[10:6];
  assign w_b = !r_use_imm ? r_rt_cont :
               r_imm_sext ? {{16{r_imm[15]}}, r_imm} : {16'h0000, r_imm};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_es_valid <= 1'b0;
    end else if (w_allowin) begin
      r_es_valid <= io_es.ds_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_we <= 1'b0;
      r_mem_re <= 1'b0;
      r_mem_we <= 1'b0;
    end else if (io_es.ds_valid && w_allowin) begin
      r_rs       <= io_es.rs_cont;
      r_rt_cont  <= io_es.rt_cont;
      r_imm      <= io_es.immediate;
      r_aluop    <= io_es.aluop;
      r_use_imm  <= io_es.use_imm;
      r_imm_sext <= io_es.imm_sext;
      r_dest     <= io_es.dst_rt ? io_es.rt : io_es.rd;
      r_reg_we   <= io_es.reg_we;
      r_mem_re   <= io_es.mem_re;
      r_mem_we   <= io_es.mem_we;
    end
  end

`ifdef MYCPU_EXE_DIV_EN
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  logic [1:0]  r_div_state;
  logic [4:0]  r_div_cnt;
  logic [31:0] r_div_q;
  logic [31:0] r_div_r;
  logic        w_is_div;
  logic [32:0] w_div_trial;
  logic [32:0] w_div_sub;

  assign w_is_div    = (r_aluop == 4'd12) || (r_aluop == 4'd13);
  // r_div_q starts as the dividend and shifts quotient bits in from the right
  assign w_div_trial = {r_div_r, r_div_q[31]};
  assign w_div_sub   = w_div_trial - {1'b0, w_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_state <= DIV_IDLE;
      r_div_cnt   <= 5'd0;
    end else begin
      case (r_div_state)
        DIV_IDLE: if (r_es_valid && w_is_div) begin
          r_div_state <= DIV_RUN;
          r_div_q     <= r_rs;
          r_div_r     <= 32'd0;
          r_div_cnt   <= 5'd0;
        end
        DIV_RUN: begin
          r_div_q   <= {r_div_q[30:0], !w_div_sub[32]};
          r_div_r   <= w_div_sub[32] ? w_div_trial[31:0] : w_div_sub[31:0];
          r_div_cnt <= r_div_cnt + 5'd1;
          if (r_div_cnt == 5'd31) r_div_state <= DIV_DONE;
        end
        DIV_DONE: if (w_to_ms_valid && io_es.ms_allowin) r_div_state <= DIV_IDLE;
        default:  r_div_state <= DIV_IDLE;
      endcase
    end
  end

  assign w_ready_go = !w_is_div || (r_div_state == DIV_DONE);
  assign w_busy     = (r_div_state != DIV_IDLE);
`else
  assign w_ready_go = 1'b1;
  assign w_busy     = 1'b0;
`endif

  always_comb begin
    w_alu = 32'd0;
    case (r_aluop)
      4'd0:  w_alu = r_rs + w_b;
      4'd1:  w_alu = r_rs - w_b;
      4'd2:  w_alu = r_rs & w_b;
      4'd3:  w_alu = r_rs | w_b;
      4'd4:  w_alu = r_rs ^ w_b;
      4'd5:  w_alu = ~(r_rs | w_b);
      4'd6:  w_alu = {31'd0, $signed(r_rs) < $signed(w_b)};
      4'd7:  w_alu = {31'd0, r_rs < w_b};
      4'd8:  w_alu = w_b << w_shamt;
      4'd9:  w_alu = w_b >> w_shamt;
      4'd10: w_alu = $unsigned($signed(w_b) >>> w_shamt);
      4'd11: w_alu = {r_imm, 16'h0000};
`ifdef MYCPU_EXE_DIV_EN
      4'd12: w_alu = r_div_q;
      4'd13: w_alu = r_div_r;
`endif
      default: w_alu = 32'd0;
    endcase
  end

  assign io_es.es_allowin     = w_allowin;
  assign io_es.es_to_ms_valid = w_to_ms_valid;
  assign io_es.es_result      = w_alu;
  assign io_es.es_store_data  = r_rt_cont;
  assign io_es.es_dest        = r_dest;
  assign io_es.es_reg_we      = r_es_valid && r_reg_we;
  assign io_es.es_mem_re      = r_es_valid && r_mem_re;
  assign io_es.es_mem_we      = r_es_valid && r_mem_we;
  assign io_es.es_busy        = w_busy;

endmodule

// File: tb/tb_mycpu_exe_stage.sv
// tb/tb_mycpu_exe_stage.sv - scoreboard bench for mycpu_exe_stage (follows MYCPU_EXE_DIV_EN)
module tb_mycpu_exe_stage;

`ifdef MYCPU_EXE_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  mycpu_exe_stage_if io_es();

  mycpu_exe_stage dut (.clk(clk), .rst(rst), .io_es(io_es));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] result;
    logic [31:0] store;
    logic [4:0]  dest;
    logic [2:0]  ctl;
    int          lat;
    int          cap;
  } exp_t;

  exp_t sb_q[$];
  bit   head_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [15:0] imm);
    logic [4:0] sa = imm[10:6];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b << sa;
      4'd9:  return b >> sa;
      4'd10: return 32'($signed(b) >>> sa);
      4'd11: return {imm, 16'h0000};
      4'd12: return !DIV_EN ? 32'd0 : (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'd13: return !DIV_EN ? 32'd0 : (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Compare at the negedge; retire the head just before the edge that hands it over.
  always @(negedge clk) begin
    if (!rst) begin
      if (io_es.es_to_ms_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_valid", 32'(io_es.es_to_ms_valid), 32'd0);
        end else begin
          if (!head_seen) begin
            check_eq("latency", 32'(cyc - sb_q[0].cap), 32'(sb_q[0].lat));
            head_seen = 1'b1;
          end
          check_eq("result", io_es.es_result, sb_q[0].result);
          check_eq("store", io_es.es_store_data, sb_q[0].store);
          check_eq("dest", 32'(io_es.es_dest), 32'(sb_q[0].dest));
          check_eq("ctl", 32'({io_es.es_reg_we, io_es.es_mem_re, io_es.es_mem_we}), 32'(sb_q[0].ctl));
          if (!io_es.ms_allowin) check_eq("stall_allowin", 32'(io_es.es_allowin), 32'd0);
        end
      end else if (sb_q.size() > 0) begin
        check_eq("wait_allowin", 32'(io_es.es_allowin), 32'd0);
      end else begin
        check_eq("empty_allowin", 32'(io_es.es_allowin), 32'd1);
        check_eq("empty_ctl", 32'({io_es.es_reg_we, io_es.es_mem_re, io_es.es_mem_we}), 32'd0);
        check_eq("empty_busy", 32'(io_es.es_busy), 32'd0);
      end
    end
    #4;
    if (!rst && io_es.es_to_ms_valid && io_es.ms_allowin && sb_q.size() > 0) begin
      void'(sb_q.pop_front());
      head_seen = 1'b0;
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [15:0] imm, input logic use_imm, input logic sext,
                      input logic dst_rt, input logic [4:0] rd_a, input logic [4:0] rt_a,
                      input logic [2:0] ctl);
    exp_t e;
    logic [31:0] opb;
    int n = 0;
    io_es.aluop = op;     io_es.rs_cont = a;       io_es.rt_cont = b;
    io_es.immediate = imm; io_es.use_imm = use_imm; io_es.imm_sext = sext;
    io_es.dst_rt = dst_rt; io_es.rd = rd_a;        io_es.rt = rt_a;
    {io_es.reg_we, io_es.mem_re, io_es.mem_we} = ctl;
    io_es.ds_valid = 1'b1;
    #1;
    while (!io_es.es_allowin && n < 300) begin
      @(negedge clk); #3; n++;
    end
    if (n >= 300) begin
      check_eq("accept_timeout", 32'(io_es.es_allowin), 32'd1);
      io_es.ds_valid = 1'b0;
      return;
    end
    opb = !use_imm ? b : sext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    e.result = alu_model(op, a, opb, imm);
    e.store  = b;
    e.dest   = dst_rt ? rt_a : rd_a;
    e.ctl    = ctl;
    e.lat    = (DIV_EN && (op == 4'd12 || op == 4'd13)) ? 33 : 0;
    e.cap    = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk); #2;
    io_es.ds_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 120) begin
      @(negedge clk); #2; n++;
    end
    if (sb_q.size() > 0) check_eq("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic stall_case(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int hold);
    io_es.ms_allowin = 1'b0;
    send(op, a, b, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd7, 5'd8, 3'b110);
    fork
      send(4'd3, 32'h0000_0011, 32'h0000_0022, 16'h0000, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 3'b001);
      begin
        repeat (hold) @(negedge clk);
        #2;
        io_es.ms_allowin = 1'b1;
      end
    join
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [3:0] op;
    io_es.ds_valid = 1'b0;  io_es.ms_allowin = 1'b1;
    io_es.rs_cont = '0;     io_es.rt_cont = '0;  io_es.rd = '0;  io_es.rt = '0;
    io_es.immediate = '0;   io_es.aluop = '0;
    io_es.use_imm = 1'b0;   io_es.imm_sext = 1'b0; io_es.dst_rt = 1'b0;
    io_es.reg_we = 1'b0;    io_es.mem_re = 1'b0;   io_es.mem_we = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(io_es.es_to_ms_valid), 32'd0);
    check_eq("rst_busy", 32'(io_es.es_busy), 32'd0);
    check_eq("rst_allowin", 32'(io_es.es_allowin), 32'd1);
    check_eq("rst_ctl", 32'({io_es.es_reg_we, io_es.es_mem_re, io_es.es_mem_we}), 32'd0);
    #2;
    rst = 1'b0;

    send(4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd3, 5'd9, 3'b100);
    send(4'd10, 32'h0000_0000, 32'h8000_0000, 16'h0100, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 3'b100);
    send(4'd6,  32'hFFFF_FFFF, 32'h0000_0001, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd4, 5'd5, 3'b100);
    send(4'd7,  32'hFFFF_FFFF, 32'h0000_0001, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd4, 5'd5, 3'b100);
    send(4'd1,  32'h0000_0000, 32'h0000_0001, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd6, 5'd7, 3'b100);
    send(4'd0,  32'h0000_0005, 32'h0000_DEAD, 16'hFFFF, 1'b1, 1'b1, 1'b1, 5'd8, 5'd9, 3'b010);
    send(4'd0,  32'h0000_0005, 32'h0000_DEAD, 16'hFFFF, 1'b1, 1'b0, 1'b1, 5'd8, 5'd9, 3'b001);
    send(4'd11, 32'h0000_0000, 32'h0000_0000, 16'h1234, 1'b1, 1'b0, 1'b1, 5'd0, 5'd31, 3'b100);
    send(4'd2,  32'hA5A5_A5A5, 32'h0F0F_0F0F, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd10, 5'd11, 3'b100);
    send(4'd3,  32'hA5A5_A5A5, 32'h0F0F_0F0F, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd10, 5'd11, 3'b100);
    send(4'd4,  32'hA5A5_A5A5, 32'h0F0F_0F0F, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd10, 5'd11, 3'b100);
    send(4'd5,  32'hA5A5_A5A5, 32'h0F0F_0F0F, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd10, 5'd11, 3'b100);
    send(4'd8,  32'h0000_0000, 32'h0000_0001, 16'h07C0, 1'b0, 1'b0, 1'b0, 5'd12, 5'd13, 3'b100);
    send(4'd9,  32'h0000_0000, 32'h8000_0000, 16'h07C0, 1'b0, 1'b0, 1'b0, 5'd12, 5'd13, 3'b100);
    send(4'd9,  32'h0000_0000, 32'h8000_0001, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd12, 5'd13, 3'b100);
    send(4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd14, 5'd15, 3'b100);
    send(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd14, 5'd15, 3'b100);
    drain();

    send(4'd12, 32'd100, 32'd7, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd16, 5'd17, 3'b100);
    send(4'd13, 32'd100, 32'd7, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd16, 5'd17, 3'b100);
    send(4'd12, 32'd5,   32'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd18, 5'd19, 3'b100);
    send(4'd13, 32'd5,   32'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd18, 5'd19, 3'b100);
    for (int i = 0; i < 4; i++)
      send(4'd12 + 4'(i % 2), $urandom, $urandom_range(1, 70000), 16'h0000,
           1'b0, 1'b0, 1'b0, 5'd20, 5'd21, 3'b100);
    send(4'd0, 32'd1, 32'd2, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd22, 5'd23, 3'b100);
    drain();

    t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      op = 4'($urandom_range(0, 13));
      if (op >= 4'd12) op = op + 4'd2;
      send(op, $urandom, $urandom, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           5'($urandom), 5'($urandom), 3'($urandom));
    end
    check_eq("b2b_cycles", 32'(cyc - t0), 32'd20);
    drain();

    stall_case(4'd0, 32'h0000_1000, 32'h0000_0234, 5);
    stall_case(4'd12, 32'd1000, 32'd9, 40);

`ifdef MYCPU_EXE_DIV_EN
    begin
      int n = 0;
      send(4'd12, 32'd1000, 32'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd24, 5'd25, 3'b100);
      while (!io_es.es_busy && n < 5) begin
        @(negedge clk); #2; n++;
      end
      check_eq("div_busy", 32'(io_es.es_busy), 32'd1);
      repeat (9) @(negedge clk);
      #2;
      sb_q.delete();
      head_seen = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_eq("abort_busy", 32'(io_es.es_busy), 32'd0);
      check_eq("abort_valid", 32'(io_es.es_to_ms_valid), 32'd0);
      check_eq("abort_allowin", 32'(io_es.es_allowin), 32'd1);
      repeat (40) @(negedge clk);
      #2;
    end
`endif

    send(4'd1, 32'd10, 32'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd26, 5'd27, 3'b100);
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
